instr_fetch_unit: RTL

Sequential instruction-fetch front end for the RISC-V core. It owns the program counter, fetches each word from instruction memory over a request/response handshake, and holds it in an instruction register. It presents the decoded fields (op_code, funct3, funct7) to the control unit and waits for the datapath to finish. It then accepts the control unit's PC_Src decision and the sign-extended immediate to form the next PC.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pc_next_calc.sv | 22 ++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: reset vector, instruction
// field positions and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_B5  = 30;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential and PC-relative targets, plus the
// alignment check on whichever target is selected.
module pc_next_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            PC_Src,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_target;

  // Both adds wrap silently at 2^XLEN.
  assign pc_plus4   = pc + XLEN'(4);
  assign pc_target  = pc + imm_ext;
  assign next_pc    = PC_Src ? pc_target : pc_plus4;
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch front end: one outstanding imem request, an instruction
// register, and a PC update driven by the control unit's PC_Src decision.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [6:0]      op_code,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            inst_done,
  input  logic            PC_Src,
  input  logic [XLEN-1:0] imm_ext,
  output logic            fetch_fault
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
    .pc         (pc),
    .imm_ext    (imm_ext),
    .PC_Src     (PC_Src),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FAULT is terminal; only reset leaves it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_REQ;
      ST_REQ:   if (imem_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_nxt = imem_err ? ST_FAULT : ST_ISSUE;
      ST_ISSUE: if (inst_done) state_nxt = misaligned ? ST_FAULT : ST_REQ;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == ST_REQ);
    inst_valid  = (state == ST_ISSUE);
    fetch_fault = (state == ST_FAULT);
  end

  // A misaligned target leaves the PC on the faulting instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= RESET_PC;
      inst <= '0;
    end else begin
      if (state == ST_WAIT && imem_rvalid && !imem_err)
        inst <= imem_rdata;
      if (state == ST_ISSUE && inst_done && !misaligned)
        pc <= next_pc;
    end
  end

  assign imem_addr  = pc;
  assign pc_current = pc;
  assign op_code    = inst[OPCODE_MSB:OPCODE_LSB];
  assign funct3     = inst[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7     = inst[FUNCT7_B5];

endmodule
